mem_stage: RTL and testbench
============================

# mem_stage

Memory stage of the five-stage RV32 pipeline. Sits directly downstream of the execute stage. Holds the E/M and M/W pipeline registers and performs byte-lane formatting for stores and loads. Runs a data-memory bus with a req/gnt/rvalid handshake, and tells the hazard unit to freeze earlier stages until the access completes.

## Interface
- None. The datapath is fixed at 32 bits; encodings come from the shared package.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  reset, asynchronous, active-low
- RegWriteE, MemWriteE  in  1 each  control from execute
- ResultSrcE  in  3  result select; RESULT_MEM (3'b001) marks a load
- StoreSrcE  in  2  store size: 00 word, 01 half, 10 byte
- LoadPartE  in  3  load kind (funct3): 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- ALUResultE, WriteDataE, PCPlus4E  in  32 each  address/result, store data, link value
- RdE  in  5  destination register
- ALUResultM  out  32  forwarding value
- RdM  out  5  forwarding destination
- RegWriteM  out  1  forwarding valid
- StallM  out  1  freezes the F/D/E stages and the E/M register
- MisalignM  out  1  misaligned access in M this cycle
- DmemReq, DmemWe  out  1 each  bus request, write enable
- DmemAddr  out  32  word address {ALUResultM[31:2],2'b00}
- DmemWData  out  32  replicated store data
- DmemBe  out  4  byte enables
- DmemGnt, DmemRValid  in  1 each  request accepted, read data valid
- DmemRData  in  32  read word
- RegWriteW, ResultSrcW, ALUResultW, ReadDataW, PCPlus4W, RdW  out  as E-side widths  write-back register

## Operation

E/M register:
- Loads all E inputs on every clock edge where StallM=0.
- Holds its contents while StallM=1.

MemOp:
- MemOp = MemWriteM | (ResultSrcM==RESULT_MEM).

Misaligned access:
- Condition: half access with addr[0]=1, or word access with addr[1:0]!=0.
- Response: MisalignM=1, no DmemReq, no stall, and RegWriteW captured as 0.

Store formatting:
- byte: WData={4{d[7:0]}}, Be=4'b0001<<addr[1:0]
- half: WData={2{d[15:0]}}, Be=addr[1]?1100:0011
- word: WData=d, Be=1111

Load extraction:
- The selected lane is addr[1:0] (byte) or addr[1] (half).
- The value is sign- or zero-extended per LoadPart.
- The result is captured into ReadDataW.

FSM, states IDLE, REQ, RDATA:
- IDLE, aligned MemOp: DmemReq=1.
  - gnt with store: complete, stay in IDLE, StallM=0.
  - gnt with load: go to RDATA, StallM=1.
  - no gnt: go to REQ, StallM=1.
- REQ: DmemReq, Addr, WData, Be and We held stable.
  - gnt with store: go to IDLE, StallM=0.
  - gnt with load: go to RDATA, StallM=1.
- RDATA: DmemReq=0.
  - rvalid: capture the load, go to IDLE, StallM=0.
  - no rvalid: StallM=1.

Bus rules:
- DmemRValid is ignored in IDLE and REQ.
- DmemGnt is ignored when DmemReq=0.

M/W register:
- Advances every cycle.
- While StallM=1 it captures a bubble: RegWriteW=0, other fields don't-care.

## Timing
- Reset (async assert, sync release) sets:
  - state IDLE
  - all E/M and M/W fields 0, so RegWriteM=MemWriteM=RegWriteW=0
  - DmemReq=0, StallM=0, MisalignM=0
- Reset mid-transaction returns to IDLE. A late rvalid after release is ignored.
- Non-memory instruction: one cycle in M. W fields are valid the cycle after it enters M.
- Store latency:
  - zero-wait gnt: 1 cycle, no stall
  - N gnt-wait cycles: N extra stall cycles
- Load latency:
  - minimum 2 cycles, meaning gnt in cycle 0 and rvalid at the earliest in cycle 1
  - always at least 1 stall cycle
- StallM is combinational from state, MemOp, alignment, DmemGnt and DmemRValid.
- StallM is 0 in the completion cycle, so the next instruction enters M at that edge.
- ALUResultM, RdM and RegWriteM stay stable throughout a stall.

## Structure
- riscv_pkg holds:
  - StoreSrc and LoadPart encodings
  - RESULT_MEM
  - the mem_state_t enum {IDLE, REQ, RDATA}
- One sub-module, lsu_align: purely combinational store formatting, load extraction and misalign detection.
- The FSM and both pipeline registers stay in mem_stage.

## Test plan
- Store byte:
  - Stimulus: ALUResultE=0x1003, WriteDataE=0xA5, StoreSrc=10, gnt the same cycle.
  - Required: Be=1000, WData=0xA5A5A5A5, Addr=0x1000, StallM=0 throughout.
- Load LH:
  - Stimulus: addr 0x2002, gnt in cycle 0, rvalid in cycle 2, RData=0x8001_1234.
  - Required: StallM high for 2 cycles, ReadDataW=0xFFFF8001, RegWriteW=1 exactly once.
- LBU with gnt delay:
  - Stimulus: gnt withheld 3 cycles.
  - Required: request fields stable, StallM=1 for 3+1 cycles, zero-extended byte written back.
- Misaligned LW:
  - Stimulus: LW at 0x3001.
  - Required: MisalignM=1 for one cycle, DmemReq=0, RegWriteW=0, no stall.
- Reset in RDATA:
  - Stimulus: rst_n asserted while in RDATA, then rvalid after release.
  - Required: state IDLE and outputs zero immediately; no write-back occurs.
- Back-to-back loads:
  - Stimulus: two consecutive loads with zero-wait gnt and rvalid.
  - Required: each spends 2 cycles in M, one bubble is inserted into W per load, and forwarding RdM stays correct.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 encodings, memory-stage FSM states and the E/M register layout.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package riscv_pkg;

   // StoreSrc encodings (store size)
   localparam logic [1:0] STORE_WORD = 2'b00;
   localparam logic [1:0] STORE_HALF = 2'b01;
   localparam logic [1:0] STORE_BYTE = 2'b10;

   // LoadPart encodings (funct3 of the load)
   localparam logic [2:0] LOAD_LB  = 3'b000;
   localparam logic [2:0] LOAD_LH  = 3'b001;
   localparam logic [2:0] LOAD_LW  = 3'b010;
   localparam logic [2:0] LOAD_LBU = 3'b100;
   localparam logic [2:0] LOAD_LHU = 3'b101;

   // ResultSrc value that marks a load
   localparam logic [2:0] RESULT_MEM = 3'b001;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      RDATA = 2'd2
   } mem_state_t;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2
   } acc_size_t;

   typedef struct packed {
      logic        reg_write;
      logic        mem_write;
      logic [2:0]  result_src;
      logic [1:0]  store_src;
      logic [2:0]  load_part;
      logic [31:0] alu_result;
      logic [31:0] write_data;
      logic [31:0] pc_plus4;
      logic [4:0]  rd;
   } em_t;

   // Stores and loads encode their size differently; fold both onto one type.
   // load_size is LoadPart[1:0]; bit 2 only selects zero-extension.
   function automatic acc_size_t access_size(input logic       mem_write,
                                             input logic [1:0] store_src,
                                             input logic [1:0] load_size);
      acc_size_t sz;
      if (mem_write) begin
         case (store_src)
            STORE_BYTE: sz = SIZE_BYTE;
            STORE_HALF: sz = SIZE_HALF;
            default:    sz = SIZE_WORD;
         endcase
      end else begin
         case (load_size)
            2'b00:   sz = SIZE_BYTE;
            2'b01:   sz = SIZE_HALF;
            default: sz = SIZE_WORD;
         endcase
      end
      return sz;
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus: req/gnt address phase, rvalid read-data phase.
// Latency: n/a (signal bundle only).
// Backpressure: slave withholds DmemGnt; master holds request fields until granted.
interface mem_stage_if;
   logic        DmemReq;
   logic        DmemWe;
   logic [31:0] DmemAddr;
   logic [31:0] DmemWData;
   logic [3:0]  DmemBe;
   logic        DmemGnt;
   logic        DmemRValid;
   logic [31:0] DmemRData;

   modport master (
      output DmemReq, DmemWe, DmemAddr, DmemWData, DmemBe,
      input  DmemGnt, DmemRValid, DmemRData
   );

   modport slave (
      input  DmemReq, DmemWe, DmemAddr, DmemWData, DmemBe,
      output DmemGnt, DmemRValid, DmemRData
   );
endinterface

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane formatting: store replication + byte enables, load extraction, misalign detect.
// Latency: purely combinational.
// Backpressure: none.
// Ports: mem_write/is_load/store_src/load_part/addr_lo/store_data/rdata in;
//        misalign/wdata/be/load_data out.
module lsu_align
   import riscv_pkg::*;
(
   input  logic        mem_write,
   input  logic        is_load,
   input  logic [1:0]  store_src,
   input  logic [2:0]  load_part,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic        misalign,
   output logic [31:0] wdata,
   output logic [3:0]  be,
   output logic [31:0] load_data
);

   acc_size_t   size;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   assign size = access_size(mem_write, store_src, load_part[1:0]);

   always_comb begin
      misalign = 1'b0;
      wdata    = store_data;
      be       = 4'b1111;
      case (size)
         SIZE_BYTE: begin
            wdata = {4{store_data[7:0]}};
            be    = 4'b0001 << addr_lo;
         end
         SIZE_HALF: begin
            wdata    = {2{store_data[15:0]}};
            be       = addr_lo[1] ? 4'b1100 : 4'b0011;
            misalign = addr_lo[0];
         end
         default: misalign = (addr_lo != 2'b00);
      endcase
      // Only a real memory access can be misaligned.
      if (!(mem_write || is_load)) misalign = 1'b0;
   end

   always_comb begin
      case (addr_lo)
         2'd0:    lane_b = rdata[7:0];
         2'd1:    lane_b = rdata[15:8];
         2'd2:    lane_b = rdata[23:16];
         default: lane_b = rdata[31:24];
      endcase
   end

   assign lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      case (load_part)
         LOAD_LB:  load_data = {{24{lane_b[7]}}, lane_b};
         LOAD_LH:  load_data = {{16{lane_h[15]}}, lane_h};
         LOAD_LBU: load_data = {24'd0, lane_b};
         LOAD_LHU: load_data = {16'd0, lane_h};
         default:  load_data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// RV32 memory stage: E/M and M/W registers, data-memory bus FSM, stall generation.
// Latency: 1 cycle for non-memory ops and zero-wait stores; loads >= 2 cycles.
// Backpressure: StallM freezes F/D/E and E/M while waiting on DmemGnt/DmemRValid.
// Ports: E-side controls/data in; forwarding (ALUResultM/RdM/RegWriteM), StallM,
//        MisalignM out; dmem bus via mem_stage_if.master; W-side register out.
module mem_stage
   import riscv_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RegWriteE,
   input  logic        MemWriteE,
   input  logic [2:0]  ResultSrcE,
   input  logic [1:0]  StoreSrcE,
   input  logic [2:0]  LoadPartE,
   input  logic [31:0] ALUResultE,
   input  logic [31:0] WriteDataE,
   input  logic [31:0] PCPlus4E,
   input  logic [4:0]  RdE,
   output logic [31:0] ALUResultM,
   output logic [4:0]  RdM,
   output logic        RegWriteM,
   output logic        StallM,
   output logic        MisalignM,
   mem_stage_if.master bus,
   output logic        RegWriteW,
   output logic [2:0]  ResultSrcW,
   output logic [31:0] ALUResultW,
   output logic [31:0] ReadDataW,
   output logic [31:0] PCPlus4W,
   output logic [4:0]  RdW
);

   em_t        em_d, em_q;
   mem_state_t state_q, state_d;
   logic       is_load, mem_op, access, req;
   logic       misalign;
   logic [31:0] wdata, load_data;
   logic [3:0]  be;

   assign em_d = '{reg_write:  RegWriteE,  mem_write:  MemWriteE,
                   result_src: ResultSrcE, store_src:  StoreSrcE,
                   load_part:  LoadPartE,  alu_result: ALUResultE,
                   write_data: WriteDataE, pc_plus4:   PCPlus4E,
                   rd:         RdE};

   // E/M register: frozen while the bus access is outstanding.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       em_q <= '0;
      else if (!StallM) em_q <= em_d;
   end

   assign ALUResultM = em_q.alu_result;
   assign RdM        = em_q.rd;
   assign RegWriteM  = em_q.reg_write;

   assign is_load = (em_q.result_src == RESULT_MEM) && !em_q.mem_write;
   assign mem_op  = em_q.mem_write || (em_q.result_src == RESULT_MEM);
   assign access  = mem_op && !misalign;

   lsu_align u_align (
      .mem_write  (em_q.mem_write),
      .is_load    (is_load),
      .store_src  (em_q.store_src),
      .load_part  (em_q.load_part),
      .addr_lo    (em_q.alu_result[1:0]),
      .store_data (em_q.write_data),
      .rdata      (bus.DmemRData),
      .misalign   (misalign),
      .wdata      (wdata),
      .be         (be),
      .load_data  (load_data)
   );

   // Request/stall decode. Request fields come straight from E/M, which is
   // held during REQ, so they stay stable until granted.
   always_comb begin
      state_d = state_q;
      req     = 1'b0;
      StallM  = 1'b0;
      case (state_q)
         IDLE: begin
            if (access) begin
               req = 1'b1;
               if (bus.DmemGnt) begin
                  if (is_load) begin
                     state_d = RDATA;
                     StallM  = 1'b1;
                  end
               end else begin
                  state_d = REQ;
                  StallM  = 1'b1;
               end
            end
         end
         REQ: begin
            req = 1'b1;
            if (bus.DmemGnt) begin
               state_d = is_load ? RDATA : IDLE;
               StallM  = is_load;
            end else begin
               StallM = 1'b1;
            end
         end
         RDATA: begin
            if (bus.DmemRValid) state_d = IDLE;
            else                StallM  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   assign MisalignM     = misalign;
   assign bus.DmemReq   = req;
   assign bus.DmemWe    = em_q.mem_write;
   assign bus.DmemAddr  = {em_q.alu_result[31:2], 2'b00};
   assign bus.DmemWData = wdata;
   assign bus.DmemBe    = be;

   // M/W register advances every cycle; stall or misalign cycles become bubbles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         RegWriteW  <= 1'b0;
         ResultSrcW <= '0;
         ALUResultW <= '0;
         ReadDataW  <= '0;
         PCPlus4W   <= '0;
         RdW        <= '0;
      end else begin
         RegWriteW  <= em_q.reg_write && !StallM && !misalign;
         ResultSrcW <= em_q.result_src;
         ALUResultW <= em_q.alu_result;
         ReadDataW  <= load_data;
         PCPlus4W   <= em_q.pc_plus4;
         RdW        <= em_q.rd;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table plus reset and back-to-back sequences.
// Latency: expected write-backs queued at M entry, compared when RegWriteW fires.
// Backpressure: bench plays the memory slave with programmable gnt/rvalid delays.
module tb_mem_stage;
   import riscv_pkg::*;

   typedef struct {
      logic        rw;
      logic        mw;
      logic [2:0]  rs;
      logic [1:0]  ss;
      logic [2:0]  lp;
      logic [31:0] alu;
      logic [31:0] wd;
      logic [31:0] pc4;
      logic [4:0]  rd;
   } einst_t;

   typedef struct {
      einst_t      e;
      int          gnt_wait;
      int          rv_wait;
      logic [31:0] rdata;
      logic        exp_mis;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      logic [31:0] exp_wb;
   } vec_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        RegWriteE, MemWriteE;
   logic [2:0]  ResultSrcE, LoadPartE;
   logic [1:0]  StoreSrcE;
   logic [31:0] ALUResultE, WriteDataE, PCPlus4E;
   logic [4:0]  RdE;
   logic [31:0] ALUResultM;
   logic [4:0]  RdM;
   logic        RegWriteM, StallM, MisalignM;
   logic        RegWriteW;
   logic [2:0]  ResultSrcW;
   logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
   logic [4:0]  RdW;

   mem_stage_if bus ();

   mem_stage dut (
      .clk(clk), .rst_n(rst_n),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
      .StoreSrcE(StoreSrcE), .LoadPartE(LoadPartE), .ALUResultE(ALUResultE),
      .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E), .RdE(RdE),
      .ALUResultM(ALUResultM), .RdM(RdM), .RegWriteM(RegWriteM),
      .StallM(StallM), .MisalignM(MisalignM), .bus(bus),
      .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
      .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .RdW(RdW)
   );

   always #5 clk = ~clk;

   int  n_checks = 0;
   int  n_pass   = 0;
   wb_t sb[$];
   vec_t vecs[12];
   einst_t nop;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp_v);
   endtask

   function automatic einst_t mk_e(input logic rw, input logic mw, input logic [2:0] rs,
                                   input logic [1:0] ss, input logic [2:0] lp,
                                   input logic [31:0] alu, input logic [31:0] wd,
                                   input logic [31:0] pc4, input logic [4:0] rd);
      einst_t e;
      e.rw = rw; e.mw = mw; e.rs = rs; e.ss = ss; e.lp = lp;
      e.alu = alu; e.wd = wd; e.pc4 = pc4; e.rd = rd;
      return e;
   endfunction

   function automatic vec_t mk_v(input einst_t e, input int gw, input int rv,
                                 input logic [31:0] rdata, input logic mis,
                                 input logic [3:0] be, input logic [31:0] wdat,
                                 input logic [31:0] wb);
      vec_t v;
      v.e = e; v.gnt_wait = gw; v.rv_wait = rv; v.rdata = rdata;
      v.exp_mis = mis; v.exp_be = be; v.exp_wdata = wdat; v.exp_wb = wb;
      return v;
   endfunction

   task automatic drive(input einst_t e);
      RegWriteE  = e.rw;  MemWriteE  = e.mw;  ResultSrcE = e.rs;
      StoreSrcE  = e.ss;  LoadPartE  = e.lp;  ALUResultE = e.alu;
      WriteDataE = e.wd;  PCPlus4E   = e.pc4; RdE        = e.rd;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called right after the edge at which v.e entered M; plays the memory
   // and checks every cycle until the instruction leaves M.
   task automatic m_phase(input string nm, input vec_t v);
      bit          mem, load, mis, exp_req;
      int          done, stalls, bad_req, bad_hold, bad_fwd, bad_bub;
      logic [31:0] a0, w0;
      logic [3:0]  b0;
      logic        we0;
      wb_t         w;
      mem  = v.e.mw || (v.e.rs == 3'b001);
      load = (v.e.rs == 3'b001) && !v.e.mw;
      mis  = v.exp_mis;
      done = (!mem || mis) ? 0 : (load ? v.gnt_wait + v.rv_wait : v.gnt_wait);
      stalls = 0; bad_req = 0; bad_hold = 0; bad_fwd = 0; bad_bub = 0;
      a0 = '0; w0 = '0; b0 = '0; we0 = 1'b0;
      if (v.e.rw && !mis) begin
         w.rd = v.e.rd; w.data = v.exp_wb;
         sb.push_back(w);
      end
      for (int k = 0; k <= done; k++) begin
         bus.DmemGnt    = mem && !mis && (k == v.gnt_wait);
         bus.DmemRValid = load && !mis && (k == v.gnt_wait + v.rv_wait);
         bus.DmemRData  = (k == v.gnt_wait + v.rv_wait) ? v.rdata : 32'h5A5A_5A5A;
         #3;
         if (StallM) stalls++;
         exp_req = mem && !mis && (k <= v.gnt_wait);
         if (bus.DmemReq !== exp_req) bad_req++;
         if (k == 0) begin
            chk({nm, "_misalign"}, 32'(MisalignM), 32'(mis));
            a0 = bus.DmemAddr; w0 = bus.DmemWData; b0 = bus.DmemBe; we0 = bus.DmemWe;
            if (mem && !mis) begin
               chk({nm, "_addr"}, bus.DmemAddr, v.e.alu & 32'hFFFF_FFFC);
               chk({nm, "_we"}, 32'(bus.DmemWe), 32'(v.e.mw));
            end
            if (v.e.mw && !mis) begin
               chk({nm, "_be"}, 32'(bus.DmemBe), 32'(v.exp_be));
               chk({nm, "_wdata"}, bus.DmemWData, v.exp_wdata);
            end
         end else if (exp_req) begin
            if (bus.DmemAddr !== a0 || bus.DmemWData !== w0 ||
                bus.DmemBe !== b0 || bus.DmemWe !== we0) bad_hold++;
         end
         if (RdM !== v.e.rd || ALUResultM !== v.e.alu || RegWriteM !== v.e.rw) bad_fwd++;
         if (k >= 1 && RegWriteW !== 1'b0) bad_bub++;
         step();
      end
      bus.DmemGnt    = 1'b0;
      bus.DmemRValid = 1'b0;
      chk({nm, "_stall_cycles"}, 32'(stalls), 32'(done));
      chk({nm, "_req_pattern_errs"}, 32'(bad_req), 32'd0);
      if (done > 0) begin
         chk({nm, "_req_hold_errs"}, 32'(bad_hold), 32'd0);
         chk({nm, "_fwd_errs"}, 32'(bad_fwd), 32'd0);
         chk({nm, "_bubble_errs"}, 32'(bad_bub), 32'd0);
      end
   endtask

   // Write-back scoreboard.
   always @(negedge clk) begin : wb_mon
      wb_t         w;
      logic [31:0] act;
      if (rst_n === 1'b1 && RegWriteW === 1'b1) begin
         n_checks++;
         act = (ResultSrcW == 3'b001) ? ReadDataW :
               (ResultSrcW == 3'b010) ? PCPlus4W  : ALUResultW;
         if (sb.size() == 0) begin
            $display("FAIL wb_unexpected: got rd=%0d data=0x%08h, expected no write-back", RdW, act);
         end else begin
            w = sb.pop_front();
            if (RdW === w.rd && act === w.data) n_pass++;
            else $display("FAIL wb_data: got rd=%0d data=0x%08h, expected rd=%0d data=0x%08h",
                          RdW, act, w.rd, w.data);
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : main
      einst_t ld1, ld2, ldr;
      nop = mk_e(1'b0, 1'b0, 3'b000, 2'b00, 3'b000, 32'd0, 32'd0, 32'd0, 5'd0);

      //                rw    mw    rs      ss     lp      alu            wd             pc4           rd
      vecs[0]  = mk_v(mk_e(1'b1, 1'b0, 3'b000, 2'b00, 3'b000, 32'h1234_5678, 32'h0,        32'h100,      5'd5),
                      0, 0, 32'h0,         1'b0, 4'b0000, 32'h0,         32'h1234_5678);
      vecs[1]  = mk_v(mk_e(1'b1, 1'b0, 3'b010, 2'b00, 3'b000, 32'h0000_ABCD, 32'h0,        32'h104,      5'd1),
                      0, 0, 32'h0,         1'b0, 4'b0000, 32'h0,         32'h0000_0104);
      vecs[2]  = mk_v(mk_e(1'b0, 1'b1, 3'b000, 2'b10, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0,      5'd0),
                      0, 0, 32'h0,         1'b0, 4'b1000, 32'hA5A5_A5A5, 32'h0);
      vecs[3]  = mk_v(mk_e(1'b0, 1'b1, 3'b000, 2'b01, 3'b000, 32'h0000_1002, 32'hBEEF_1234, 32'h0,      5'd0),
                      2, 0, 32'h0,         1'b0, 4'b1100, 32'h1234_1234, 32'h0);
      vecs[4]  = mk_v(mk_e(1'b0, 1'b1, 3'b000, 2'b00, 3'b000, 32'h0000_1004, 32'hCAFE_F00D, 32'h0,      5'd0),
                      0, 0, 32'h0,         1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0);
      vecs[5]  = mk_v(mk_e(1'b1, 1'b0, 3'b001, 2'b00, 3'b001, 32'h0000_2002, 32'h0,        32'h0,        5'd7),
                      0, 2, 32'h8001_1234, 1'b0, 4'b0000, 32'h0,         32'hFFFF_8001);
      vecs[6]  = mk_v(mk_e(1'b1, 1'b0, 3'b001, 2'b00, 3'b100, 32'h0000_2001, 32'h0,        32'h0,        5'd9),
                      3, 1, 32'h1122_C344, 1'b0, 4'b0000, 32'h0,         32'h0000_00C3);
      vecs[7]  = mk_v(mk_e(1'b1, 1'b0, 3'b001, 2'b00, 3'b010, 32'h0000_3001, 32'h0,        32'h0,        5'd10),
                      0, 1, 32'h0,         1'b1, 4'b0000, 32'h0,         32'h0);
      vecs[8]  = mk_v(mk_e(1'b1, 1'b0, 3'b001, 2'b00, 3'b000, 32'h0000_2003, 32'h0,        32'h0,        5'd11),
                      1, 1, 32'h8500_0000, 1'b0, 4'b0000, 32'h0,         32'hFFFF_FF85);
      vecs[9]  = mk_v(mk_e(1'b1, 1'b0, 3'b001, 2'b00, 3'b010, 32'h0000_2008, 32'h0,        32'h0,        5'd12),
                      0, 1, 32'hDEAD_BEEF, 1'b0, 4'b0000, 32'h0,         32'hDEAD_BEEF);
      vecs[10] = mk_v(mk_e(1'b1, 1'b0, 3'b001, 2'b00, 3'b101, 32'h0000_200A, 32'h0,        32'h0,        5'd13),
                      0, 3, 32'h9ABC_0000, 1'b0, 4'b0000, 32'h0,         32'h0000_9ABC);
      vecs[11] = mk_v(mk_e(1'b0, 1'b1, 3'b000, 2'b01, 3'b000, 32'h0000_1001, 32'h0000_1234, 32'h0,      5'd0),
                      0, 0, 32'h0,         1'b1, 4'b0000, 32'h0,         32'h0);

      // Reset state: E inputs busy, everything downstream must stay zero.
      rst_n = 1'b0;
      bus.DmemGnt = 1'b0; bus.DmemRValid = 1'b0; bus.DmemRData = 32'h0;
      drive(vecs[5].e);
      step(); step();
      #2;
      chk("rst_RegWriteM", 32'(RegWriteM), 32'd0);
      chk("rst_RdM",       32'(RdM),       32'd0);
      chk("rst_RegWriteW", 32'(RegWriteW), 32'd0);
      chk("rst_DmemReq",   32'(bus.DmemReq), 32'd0);
      chk("rst_StallM",    32'(StallM),    32'd0);
      chk("rst_MisalignM", 32'(MisalignM), 32'd0);
      drive(nop);
      step();
      rst_n = 1'b1;
      step();

      foreach (vecs[i]) begin
         drive(vecs[i].e);
         step();
         drive(nop);
         m_phase($sformatf("v%0d", i), vecs[i]);
      end

      // Back-to-back loads, zero-wait gnt and rvalid.
      ld1 = mk_e(1'b1, 1'b0, 3'b001, 2'b00, 3'b010, 32'h0000_2010, 32'h0, 32'h0, 5'd14);
      ld2 = mk_e(1'b1, 1'b0, 3'b001, 2'b00, 3'b010, 32'h0000_2014, 32'h0, 32'h0, 5'd15);
      drive(ld1);
      step();
      drive(ld2);
      m_phase("b2b_ld1", mk_v(ld1, 0, 1, 32'h0102_0304, 1'b0, 4'b0, 32'h0, 32'h0102_0304));
      drive(nop);
      m_phase("b2b_ld2", mk_v(ld2, 0, 1, 32'h0506_0708, 1'b0, 4'b0, 32'h0, 32'h0506_0708));
      step(); step();

      // Reset while waiting in RDATA; the late rvalid must be ignored.
      ldr = mk_e(1'b1, 1'b0, 3'b001, 2'b00, 3'b010, 32'h0000_2020, 32'h0, 32'h0, 5'd20);
      drive(ldr);
      step();
      drive(nop);
      bus.DmemGnt = 1'b1;
      #3;
      chk("rstx_gnt_stall", 32'(StallM), 32'd1);
      chk("rstx_gnt_req",   32'(bus.DmemReq), 32'd1);
      step();
      bus.DmemGnt = 1'b0;
      #2;
      chk("rstx_rdata_stall", 32'(StallM), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rstx_state",     32'(dut.state_q), 32'(IDLE));
      chk("rstx_DmemReq",   32'(bus.DmemReq), 32'd0);
      chk("rstx_StallM",    32'(StallM),      32'd0);
      chk("rstx_RegWriteM", 32'(RegWriteM),   32'd0);
      chk("rstx_RegWriteW", 32'(RegWriteW),   32'd0);
      chk("rstx_RdM",       32'(RdM),         32'd0);
      step();
      rst_n = 1'b1;
      step();
      bus.DmemRValid = 1'b1;
      bus.DmemRData  = 32'hFFFF_FFFF;
      #3;
      chk("rstx_late_rv_stall", 32'(StallM),      32'd0);
      chk("rstx_late_rv_req",   32'(bus.DmemReq), 32'd0);
      step();
      bus.DmemRValid = 1'b0;
      #3;
      chk("rstx_no_wb", 32'(RegWriteW), 32'd0);
      step(); step();

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
